udp_bridge_core_gpio: RTL and testbench

UDP_BRIDGE_CORE_GPIO -- requirements
Module: udp_bridge_core_gpio

---
 rtl/udp_bridge_core_gpio.sv | 142 ++++++++++++++
 tb/tb_udp_bridge_core_gpio.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/udp_bridge_core_gpio.sv
// Memory-mapped GPIO block with output data, direction, edge capture and an optional masked interrupt.
// Optional interrupt: define UDP_BRIDGE_GPIO_IRQ_EN to add the IRQ_MASK register and the irq port.
module udp_bridge_core_gpio #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_en
`ifdef UDP_BRIDGE_GPIO_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE     = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap_clr;
    logic             wr_en;

    assign wr_en = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_wdata_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^writedata[31:WIDTH];
        end
    endgenerate

    // sync2_q is in_sync; prev_q is the extra stage the edge detector compares against
    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_det = sync2_q & ~prev_q;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_det = ~sync2_q & prev_q;
        end else begin : g_any
            assign edge_det = sync2_q ^ prev_q;
        end
    endgenerate

    always_comb begin
        data_d = data_q;
        dir_d  = dir_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_d = wdata;
                ADDR_DIR:      dir_d  = wdata;
                ADDR_OUTSET:   data_d = data_q | wdata;
                ADDR_OUTCLEAR: data_d = data_q & ~wdata;
                default:       ;
            endcase
        end
    end

    // A fresh edge is OR-ed in after the clear so it survives a same-cycle write-1-clear
    always_comb begin
        cap_clr = '0;
        if (wr_en && (address == ADDR_EDGE)) begin
            cap_clr = wdata;
        end
        cap_d = (cap_q & ~cap_clr) | edge_det;
    end

`ifdef UDP_BRIDGE_GPIO_IRQ_EN
    logic [WIDTH-1:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if (wr_en && (address == ADDR_IRQ_MASK)) begin
            mask_d = wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign irq = |(cap_q & mask_q);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= RESET_VALUE;
            dir_q   <= '0;
            cap_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            data_q  <= data_d;
            dir_q   <= dir_d;
            cap_q   <= cap_d;
            sync1_q <= in_port;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Zero-wait-state read path: pure function of address and register state
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0] = sync2_q;
            ADDR_DIR:      readdata[WIDTH-1:0] = dir_q;
`ifdef UDP_BRIDGE_GPIO_IRQ_EN
            ADDR_IRQ_MASK: readdata[WIDTH-1:0] = mask_q;
`endif
            ADDR_EDGE:     readdata[WIDTH-1:0] = cap_q;
            ADDR_OUTSET:   readdata[WIDTH-1:0] = data_q;
            ADDR_OUTCLEAR: readdata[WIDTH-1:0] = data_q;
            default:       readdata = '0;
        endcase
    end

    assign out_port = data_q;
    assign out_en   = dir_q;

endmodule

// File: tb/tb_udp_bridge_core_gpio.sv
// Directed bench for udp_bridge_core_gpio (WIDTH=8, RESET_VALUE=0x5A, rising-edge capture).
module tb_udp_bridge_core_gpio;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic [7:0]  out_en;
`ifdef UDP_BRIDGE_GPIO_IRQ_EN
    logic        irq;
`endif

    int n_chk = 0;
    int n_bad = 0;

    udp_bridge_core_gpio #(
        .WIDTH      (8),
        .RESET_VALUE(8'h5A),
        .EDGE_TYPE  (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .out_port  (out_port),
        .out_en    (out_en)
`ifdef UDP_BRIDGE_GPIO_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        address = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'h00;

        @(negedge clk);
        chk("rst_out_port", {24'h0, out_port}, 32'h5A);
        chk("rst_out_en", {24'h0, out_en}, 32'h00);
        rd(3'd3, 32'h0, "rst_edge");
        reset = 1'b0;

        @(negedge clk);
        chk("post_rst_out_port", {24'h0, out_port}, 32'h5A);
        chk("post_rst_out_en", {24'h0, out_en}, 32'h00);
        rd(3'd0, 32'h0, "post_rst_data");

        // DATA / OUTSET / OUTCLEAR: 0x0F | 0xA0 = 0xAF, & ~0x03 = 0xAC
        wr(3'd0, 32'h0F);
        chk("data_wr", {24'h0, out_port}, 32'h0F);
        wr(3'd4, 32'hA0);
        chk("outset", {24'h0, out_port}, 32'hAF);
        wr(3'd5, 32'h03);
        chk("outclear", {24'h0, out_port}, 32'hAC);
        rd(3'd5, 32'h0000_00AC, "rd_outclear");
        rd(3'd4, 32'h0000_00AC, "rd_outset");
        chk("dir_untouched", {24'h0, out_en}, 32'h00);

        wr(3'd1, 32'hFFFF_FF3C);
        chk("out_en", {24'h0, out_en}, 32'h3C);
        rd(3'd1, 32'h0000_003C, "rd_dir_zext");

        wr(3'd6, 32'hFF);
        wr(3'd7, 32'h00);
        rd(3'd6, 32'h0, "rd_rsvd6");
        rd(3'd7, 32'h0, "rd_rsvd7");
        chk("rsvd_no_effect", {24'h0, out_port}, 32'hAC);

        // Capture latency: DATA after 2 edges, EDGE_CAPTURE after 3
        in_port = 8'h81;
        @(negedge clk);
        rd(3'd0, 32'h00, "sync_1edge");
        @(negedge clk);
        rd(3'd0, 32'h81, "sync_2edge");
        rd(3'd3, 32'h00, "cap_2edge");
        @(negedge clk);
        rd(3'd3, 32'h81, "cap_3edge");

        wr(3'd3, 32'h01);
        rd(3'd3, 32'h80, "cap_clr_bit0");
        wr(3'd3, 32'h00);
        rd(3'd3, 32'h80, "cap_wr0_hold");

        in_port = 8'h80;
        repeat (4) @(negedge clk);
        rd(3'd3, 32'h80, "no_fall_capture");

        // Rising edge on bit 0 lands on the same edge as a write-1-clear of bit 0
        in_port = 8'h81;
        @(negedge clk);
        @(negedge clk);
        address    = 3'd3;
        writedata  = 32'h01;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        rd(3'd3, 32'h81, "set_wins");

`ifdef UDP_BRIDGE_GPIO_IRQ_EN
        chk("irq_no_mask", {31'h0, irq}, 32'h0);
        wr(3'd2, 32'h80);
        rd(3'd2, 32'h80, "rd_mask");
        chk("irq_set", {31'h0, irq}, 32'h1);
        wr(3'd3, 32'h80);
        chk("irq_clr", {31'h0, irq}, 32'h0);
        rd(3'd3, 32'h01, "cap_after_irq_clr");
        wr(3'd3, 32'h01);
`else
        wr(3'd2, 32'hFF);
        rd(3'd2, 32'h0, "rd_no_mask");
        wr(3'd3, 32'h81);
`endif
        rd(3'd3, 32'h00, "cap_cleared");

        in_port = 8'h00;
        repeat (4) @(negedge clk);
        in_port = 8'hFF;
        repeat (4) @(negedge clk);
        rd(3'd3, 32'hFF, "cap_ff");
        wr(3'd0, 32'h55);
        chk("out_55", {24'h0, out_port}, 32'h55);

        // Asynchronous reset between clock edges
        #1 reset = 1'b1;
        #1;
        chk("arst_out_port", {24'h0, out_port}, 32'h5A);
        chk("arst_out_en", {24'h0, out_en}, 32'h00);
`ifdef UDP_BRIDGE_GPIO_IRQ_EN
        chk("arst_irq", {31'h0, irq}, 32'h0);
`endif
        address = 3'd3;
        #1;
        chk("arst_cap", readdata, 32'h0);
        address = 3'd0;
        #1;
        chk("arst_sync", readdata, 32'h0);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rd(3'd3, 32'h00, "post_arst_2edge");
        @(negedge clk);
        rd(3'd3, 32'hFF, "post_arst_3edge");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
